// File: rtl/spi_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_access_arbiter_pkg
// Description : Shared types and constants for the SPI access arbiter.
//               Holds the arbiter FSM state encoding, the default timeout
//               and the SPI package width used to size the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_access_arbiter_pkg;

    // Width of one SPI data package; the register address is one bit narrower.
    localparam int CAC_SPI_PACKAGE_WIDTH = 8;

    // Default abort limit for the busy-rise and busy-fall waits.
    localparam int ARB_TIMEOUT_DEFAULT = 4096;

    typedef enum logic [2:0] {
        ARB_IDLE      = 3'd0,
        ARB_LAUNCH    = 3'd1,
        ARB_WAIT_BUSY = 3'd2,
        ARB_WAIT_DONE = 3'd3,
        ARB_RESPOND   = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_access_arbiter_if
// Description : Bundle of requester-side and SPI-driver-side signals of the
//               SPI access arbiter.
//               slave  : arbiter view (requests/SPI status in, grants/SPI
//                        commands out)
//               master : environment view (requesters + SPI driver)
//               req_addr/req_data are flattened, requester i at
//               [i*(PACKAGE_SIZE-1) +: PACKAGE_SIZE-1] / [i*PACKAGE_SIZE +: PACKAGE_SIZE].
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_access_arbiter_if #(
    parameter int PACKAGE_SIZE = 8,
    parameter int NUM_REQ      = 2
);
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  req_rw;
    logic [NUM_REQ*(PACKAGE_SIZE-1)-1:0] req_addr;
    logic [NUM_REQ*PACKAGE_SIZE-1:0]     req_data;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [NUM_REQ-1:0]                  rsp_valid;
    logic                                rsp_err;
    logic [PACKAGE_SIZE-1:0]             rsp_data;
    logic                                spi_rw_op;
    logic [PACKAGE_SIZE-2:0]             spi_addr;
    logic [PACKAGE_SIZE-1:0]             spi_data;
    logic                                spi_send;
    logic                                spi_busy;
    logic                                spi_data_ready;
    logic [PACKAGE_SIZE-1:0]             spi_data_out;

    modport slave (
        input  req_valid, req_rw, req_addr, req_data,
        input  spi_busy, spi_data_ready, spi_data_out,
        output req_ready, rsp_valid, rsp_err, rsp_data,
        output spi_rw_op, spi_addr, spi_data, spi_send
    );

    modport master (
        output req_valid, req_rw, req_addr, req_data,
        output spi_busy, spi_data_ready, spi_data_out,
        input  req_ready, rsp_valid, rsp_err, rsp_data,
        input  spi_rw_op, spi_addr, spi_data, spi_send
    );
endinterface
`default_nettype wire

// File: rtl/spi_access_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : spi_rr_arbiter
// Description : Combinational round-robin winner selection.
//               req_valid  : pending requests, one bit per requester
//               last_grant : index of the requester served last
//               any_valid  : at least one request pending
//               winner     : index of the selected requester
//               grant      : one-hot form of winner (0 when none pending)
//               The search starts at last_grant+1 and wraps at NUM_REQ-1,
//               so the most recently served requester has lowest priority.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rr_arbiter
    import spi_access_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               any_valid,
    output logic [IDX_W-1:0]   winner,
    output logic [NUM_REQ-1:0] grant
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        w_idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!any_valid && req_valid[w_idx]) begin
                any_valid = 1'b1;
                winner    = w_idx;
            end
        end
        grant = any_valid ? (NUM_REQ'(1) << winner) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/spi_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_access_arbiter
// Description : Shares one SPI master among NUM_REQ requesters. One
//               transaction in flight; the grant is held until the SPI
//               driver raises and drops busy (or the wait times out), then
//               a per-requester response pulse is returned.
//               clk  : system clock
//               rstb : synchronous active-low reset
//               bus  : requester handshake + SPI driver signals (slave view)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_access_arbiter
    import spi_access_arbiter_pkg::*;
#(
    parameter int PACKAGE_SIZE   = CAC_SPI_PACKAGE_WIDTH,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstb,
    spi_access_arbiter_if.slave   bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW    = PACKAGE_SIZE - 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    arb_state_t              r_state, w_state_n;
    logic [IDX_W-1:0]        r_ptr, w_ptr_n;
    logic [IDX_W-1:0]        r_owner, w_owner_n;
    logic [CNT_W-1:0]        r_cnt, w_cnt_n;
    logic                    r_rw, w_rw_n;
    logic [AW-1:0]           r_addr, w_addr_n;
    logic [PACKAGE_SIZE-1:0] r_data, w_data_n;
    logic                    r_send, w_send_n;
    logic [NUM_REQ-1:0]      r_req_ready, w_req_ready_n;
    logic [NUM_REQ-1:0]      r_rsp_valid, w_rsp_valid_n;
    logic                    r_rsp_err, w_rsp_err_n;
    logic [PACKAGE_SIZE-1:0] r_rsp_data, w_rsp_data_n;
    logic [PACKAGE_SIZE-1:0] r_cap, w_cap_n;
    logic                    r_got, w_got_n;

    logic                    w_any;
    logic [IDX_W-1:0]        w_winner;
    logic [NUM_REQ-1:0]      w_grant;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic                    w_timeout;
    logic                    w_dr_hit;
    logic                    w_done;
    logic                    w_err;

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_valid  (bus.req_valid),
        .last_grant (r_ptr),
        .any_valid  (w_any),
        .winner     (w_winner),
        .grant      (w_grant)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state     <= ARB_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_send      <= 1'b0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_cap       <= '0;
            r_got       <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_ptr       <= w_ptr_n;
            r_owner     <= w_owner_n;
            r_cnt       <= w_cnt_n;
            r_rw        <= w_rw_n;
            r_addr      <= w_addr_n;
            r_data      <= w_data_n;
            r_send      <= w_send_n;
            r_req_ready <= w_req_ready_n;
            r_rsp_valid <= w_rsp_valid_n;
            r_rsp_err   <= w_rsp_err_n;
            r_rsp_data  <= w_rsp_data_n;
            r_cap       <= w_cap_n;
            r_got       <= w_got_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_ptr_n       = r_ptr;
        w_owner_n     = r_owner;
        w_cnt_n       = r_cnt;
        w_rw_n        = r_rw;
        w_addr_n      = r_addr;
        w_data_n      = r_data;
        w_send_n      = 1'b0;
        w_req_ready_n = '0;
        w_rsp_valid_n = '0;
        w_rsp_err_n   = r_rsp_err;
        w_rsp_data_n  = r_rsp_data;
        w_cap_n       = r_cap;
        w_got_n       = r_got;
        w_done        = 1'b0;
        w_err         = 1'b0;

        // Saturating increment; the abort fires on the cycle the count
        // would reach the limit, so a wait lasts at most TIMEOUT_CYCLES.
        w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        w_timeout = (w_cnt_inc == c_CNT_MAX);
        w_dr_hit  = r_rw && bus.spi_data_ready;

        case (r_state)
            ARB_IDLE: begin
                if (w_any && !bus.spi_busy) begin
                    w_owner_n     = w_winner;
                    w_rw_n        = bus.req_rw[w_winner];
                    w_addr_n      = bus.req_addr[w_winner*AW +: AW];
                    w_data_n      = bus.req_data[w_winner*PACKAGE_SIZE +: PACKAGE_SIZE];
                    w_req_ready_n = w_grant;
                    w_cnt_n       = '0;
                    w_cap_n       = '0;
                    w_got_n       = 1'b0;
                    w_state_n     = ARB_LAUNCH;
                end
            end
            ARB_LAUNCH: begin
                w_send_n  = 1'b1;
                w_state_n = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
                if (bus.spi_busy) begin
                    w_cnt_n   = '0;
                    w_state_n = ARB_WAIT_DONE;
                end else if (w_timeout) begin
                    w_done = 1'b1;
                    w_err  = 1'b1;
                end else begin
                    w_cnt_n = w_cnt_inc;
                end
            end
            ARB_WAIT_DONE: begin
                if (!bus.spi_busy) begin
                    w_done = 1'b1;
                    // A pulse on the final edge still counts as read data.
                    w_err  = r_rw && !(r_got || w_dr_hit);
                end else if (w_timeout) begin
                    w_done = 1'b1;
                    w_err  = 1'b1;
                end else begin
                    w_cnt_n = w_cnt_inc;
                end
            end
            ARB_RESPOND: begin
                w_ptr_n   = r_owner;
                w_state_n = ARB_IDLE;
            end
            default: begin
                w_state_n = ARB_IDLE;
            end
        endcase

        if ((r_state == ARB_WAIT_BUSY) || (r_state == ARB_WAIT_DONE)) begin
            if (w_dr_hit) begin
                w_cap_n = bus.spi_data_out;
                w_got_n = 1'b1;
            end
        end

        if (w_done) begin
            w_state_n     = ARB_RESPOND;
            w_rsp_valid_n = NUM_REQ'(1) << r_owner;
            w_rsp_err_n   = w_err;
            if (w_err || !r_rw) begin
                w_rsp_data_n = '0;
            end else begin
                w_rsp_data_n = w_dr_hit ? bus.spi_data_out : r_cap;
            end
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.spi_rw_op = r_rw;
    assign bus.spi_addr  = r_addr;
    assign bus.spi_data  = r_data;
    assign bus.spi_send  = r_send;

endmodule
`default_nettype wire

// File: tb/tb_spi_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_access_arbiter
// Description : Self-checking bench for spi_access_arbiter. Requesters and
//               the SPI driver are modelled behaviourally; expected grants
//               come from a round-robin rule on the last served requester,
//               expected responses from what the modelled driver returned.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_access_arbiter;

    localparam int PS   = 8;
    localparam int NREQ = 2;
    localparam int AW   = PS - 1;
    localparam int TMO  = 16;

    logic clk;
    logic rstb;

    spi_access_arbiter_if #(.PACKAGE_SIZE(PS), .NUM_REQ(NREQ)) bus();

    spi_access_arbiter #(
        .PACKAGE_SIZE   (PS),
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int last_grant;

    logic          t_rw   [NREQ];
    logic [AW-1:0] t_addr [NREQ];
    logic [PS-1:0] t_data [NREQ];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Next requester after the last one served, wrapping around.
    function automatic int rr_pick(input logic [NREQ-1:0] m);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(last_grant + k) % NREQ]) return (last_grant + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic post(input int i, input logic rw, input logic [AW-1:0] a, input logic [PS-1:0] d);
        t_rw[i]   = rw;
        t_addr[i] = a;
        t_data[i] = d;
        bus.req_rw[i]              = rw;
        bus.req_addr[i*AW +: AW]   = a;
        bus.req_data[i*PS +: PS]   = d;
        bus.req_valid[i]           = 1'b1;
    endtask

    task automatic post_rand(input int i);
        post(i, 1'($urandom_range(0, 1)), AW'($urandom), PS'($urandom));
    endtask

    // Grant must appear exactly maxcyc negedges from now, to the model's pick.
    task automatic wait_grant(input int maxcyc, output int w);
        int exp_w;
        exp_w = rr_pick(bus.req_valid);
        for (int i = 1; i <= maxcyc; i++) begin
            @(negedge clk);
            if (i < maxcyc) chk("no_early_ready", 32'(bus.req_ready), 0);
        end
        chk("grant", 32'(bus.req_ready), 32'(1) << exp_w);
        w = exp_w;
        chk("spi_rw", 32'(bus.spi_rw_op), 32'(t_rw[w]));
        chk("spi_addr", 32'(bus.spi_addr), 32'(t_addr[w]));
        chk("spi_data", 32'(bus.spi_data), 32'(t_data[w]));
        bus.req_valid[w] = 1'b0;
    endtask

    // blen==0: driver never raises busy, so the wait must time out.
    task automatic run_spi(input int w, input int dly, input int blen, input int ndr, input int dval);
        logic          exp_err;
        logic [PS-1:0] exp_data;
        logic [PS-1:0] lastv;
        int n;
        @(negedge clk);
        chk("send_pulse", 32'(bus.spi_send), 1);
        chk("ready_one_cycle", 32'(bus.req_ready), 0);
        if (blen == 0) begin
            n = 0;
            while (bus.rsp_valid == '0 && n < 4*TMO) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_latency", 32'(n), TMO);
            exp_err  = 1'b1;
            exp_data = '0;
        end else begin
            @(negedge clk);
            chk("send_one_cycle", 32'(bus.spi_send), 0);
            repeat (dly) @(negedge clk);
            bus.spi_busy = 1'b1;
            lastv = '0;
            for (int c = 0; c < blen; c++) begin
                if (c < ndr) begin
                    bus.spi_data_ready = 1'b1;
                    bus.spi_data_out   = (dval >= 0) ? PS'(dval) : PS'($urandom);
                    lastv              = bus.spi_data_out;
                end else begin
                    bus.spi_data_ready = 1'b0;
                end
                @(negedge clk);
            end
            bus.spi_data_ready = 1'b0;
            bus.spi_busy       = 1'b0;
            @(negedge clk);
            exp_err  = t_rw[w] && (ndr == 0);
            exp_data = (exp_err || !t_rw[w]) ? '0 : lastv;
        end
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << w);
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        chk("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
        last_grant = w;
        @(negedge clk);
        chk("rsp_one_cycle", 32'(bus.rsp_valid), 0);
        chk("rsp_err_hold", 32'(bus.rsp_err), 32'(exp_err));
        chk("rsp_data_hold", 32'(bus.rsp_data), 32'(exp_data));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
        chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
        chk({tag, "_spi_send"}, 32'(bus.spi_send), 0);
        chk({tag, "_spi_rw"}, 32'(bus.spi_rw_op), 0);
        chk({tag, "_spi_addr"}, 32'(bus.spi_addr), 0);
        chk({tag, "_spi_data"}, 32'(bus.spi_data), 0);
    endtask

    initial begin
        int w;
        int blen;
        rstb               = 1'b0;
        bus.req_valid      = '0;
        bus.req_rw         = '0;
        bus.req_addr       = '0;
        bus.req_data       = '0;
        bus.spi_busy       = 1'b0;
        bus.spi_data_ready = 1'b0;
        bus.spi_data_out   = '0;
        last_grant         = 0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rstb = 1'b1;

        // Single write, stray data_ready must be ignored
        post(0, 1'b0, 7'h24, 8'hCC);
        wait_grant(1, w);
        run_spi(w, 1, 3, 1, -1);

        // Single read returning 0x0F
        post(1, 1'b1, 7'h28, 8'h00);
        wait_grant(1, w);
        run_spi(w, 0, 4, 1, 8'h0F);

        // Contention: both pending, winner reposts after its response
        post_rand(0);
        post_rand(1);
        for (int k = 0; k < 4; k++) begin
            wait_grant(1, w);
            blen = $urandom_range(1, 6);
            run_spi(w, $urandom_range(0, 3), blen, $urandom_range(0, blen), -1);
            post_rand(w);
        end
        bus.req_valid = '0;
        @(negedge clk);

        // Timeout: busy never rises, then a normal read
        post(0, 1'b1, AW'($urandom), PS'($urandom));
        wait_grant(1, w);
        run_spi(w, 0, 0, 0, -1);
        post(1, 1'b1, AW'($urandom), PS'($urandom));
        wait_grant(1, w);
        run_spi(w, 2, 3, 1, 8'h5A);

        // Reset during WAIT_DONE of a read
        post(1, 1'b1, AW'($urandom), PS'($urandom));
        wait_grant(1, w);
        @(negedge clk);
        chk("rstmid_send", 32'(bus.spi_send), 1);
        @(negedge clk);
        bus.spi_busy = 1'b1;
        repeat (3) @(negedge clk);
        bus.spi_data_ready = 1'b1;
        bus.spi_data_out   = 8'hA5;
        rstb = 1'b0;
        @(negedge clk);
        chk_all_zero("rstmid");
        bus.spi_data_ready = 1'b0;
        bus.spi_busy       = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_no_rsp", 32'(bus.rsp_valid), 0);
        end
        last_grant = 0;
        post_rand(0);
        post_rand(1);
        rstb = 1'b1;
        wait_grant(1, w);
        run_spi(w, 1, 2, 1, -1);
        wait_grant(1, w);
        run_spi(w, 0, 2, 2, -1);

        // Driver busy while a request is pending
        bus.spi_busy = 1'b1;
        post_rand(0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("busy_idle_hold", 32'(bus.req_ready), 0);
        end
        bus.spi_busy = 1'b0;
        wait_grant(1, w);
        run_spi(w, 1, 2, 1, -1);

        // Randomised traffic, including occasional timeouts
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] && ($urandom_range(0, 1) == 1)) post_rand(i);
            end
            if (bus.req_valid == '0) post_rand($urandom_range(0, NREQ-1));
            wait_grant(1, w);
            blen = $urandom_range(0, 6);
            run_spi(w, $urandom_range(0, 3), blen, $urandom_range(0, blen), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
